// File: rtl/fc_argmax_stream.sv
// Argmax over one streamed vector of M signed activations.
// Emits the winning index and value as a single result beat.
module fc_argmax_stream #(
    parameter int WIDTH = 16,
    parameter int M     = 6,
    parameter int LOGM  = $clog2(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] input_data,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [LOGM-1:0]  output_index,
    output logic [WIDTH-1:0] output_value,
    output logic [15:0]      vec_count
);

    typedef enum logic {
        COLLECT,
        RESULT
    } state_t;

    localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

    state_t                   state_q, state_d;
    logic [LOGM-1:0]          cnt_q, cnt_d;
    logic [LOGM-1:0]          idx_q, idx_d;
    logic signed [WIDTH-1:0]  max_q, max_d;
    logic [LOGM-1:0]          oidx_q, oidx_d;
    logic [WIDTH-1:0]         oval_q, oval_d;
    logic [15:0]              vc_q, vc_d;
    logic                     in_acc;
    logic                     out_acc;
    logic                     take;

    assign input_ready  = (state_q == COLLECT);
    assign output_valid = (state_q == RESULT);
    assign output_index = oidx_q;
    assign output_value = oval_q;
    assign vec_count    = vc_q;

    assign in_acc  = input_valid && (state_q == COLLECT);
    assign out_acc = output_ready && (state_q == RESULT);

    // Strict compare keeps the lowest index on ties; element 0 always seeds.
    assign take = (cnt_q == '0) ||
                  ($signed(input_data) > max_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        max_d   = max_q;
        oidx_d  = oidx_q;
        oval_d  = oval_q;
        vc_d    = vc_q;
        unique case (state_q)
            COLLECT: begin
                if (in_acc) begin
                    if (take) begin
                        max_d = $signed(input_data);
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        oidx_d  = idx_d;
                        oval_d  = max_d;
                        state_d = RESULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                if (out_acc) begin
                    vc_d    = vc_q + 16'd1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            oidx_q  <= '0;
            oval_q  <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            oidx_q  <= oidx_d;
            oval_q  <= oval_d;
            vc_q    <= vc_d;
        end
    end

endmodule

// File: tb/tb_fc_argmax_stream.sv
// Directed bench for fc_argmax_stream (M=6, WIDTH=16).
// Each scenario task drives a vector and checks the result beat inline.
module tb_fc_argmax_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic [15:0] input_data = '0;
    logic        output_valid;
    logic        output_ready = 1'b0;
    logic [2:0]  output_index;
    logic [15:0] output_value;
    logic [15:0] vec_count;

    int checks = 0;
    int failures = 0;

    fc_argmax_stream #(.WIDTH(16), .M(6)) dut (
        .clk(clk),
        .reset(reset),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .input_data(input_data),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_index(output_index),
        .output_value(output_value),
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until accepted (bounded wait).
    task automatic push(input logic [15:0] d);
        int n;
        n = 0;
        input_valid = 1'b1;
        input_data  = d;
        while (!input_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!input_ready) begin
            failures++;
            $display("FAIL push_timeout got ready=%0b want 1", input_ready);
        end
        tick();
        input_valid = 1'b0;
    endtask

    task automatic chk_result(input string nm, input logic [2:0] ei,
                              input logic [15:0] ev);
        checks++;
        if (output_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid got %0b want 1", nm, output_valid);
        end
        checks++;
        if (output_index !== ei) begin
            failures++;
            $display("FAIL %s_index got %0d want %0d", nm, output_index, ei);
        end
        checks++;
        if (output_value !== ev) begin
            failures++;
            $display("FAIL %s_value got %0d want %0d", nm,
                     $signed(output_value), $signed(ev));
        end
    endtask

    task automatic chk_after(input string nm, input logic [15:0] evc);
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_hs got ov=%0b ir=%0b want ov=0 ir=1",
                     nm, output_valid, input_ready);
        end
        checks++;
        if (vec_count !== evc) begin
            failures++;
            $display("FAIL %s_vc got %0d want %0d", nm, vec_count, evc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        output_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got ir=%0b ov=%0b want ir=1 ov=0",
                     input_ready, output_valid);
        end
        checks++;
        if (output_index !== 3'd0 || output_value !== 16'd0) begin
            failures++;
            $display("FAIL reset_out got %0d/%0d want 0/0",
                     output_index, output_value);
        end
        checks++;
        if (vec_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_vc got %0d want 0", vec_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] v[6];
        v = '{16'd3, -16'sd7, 16'd12, 16'd5, 16'd12, -16'sd1};
        output_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(v[i]);
        chk_result("basic", 3'd2, 16'd12);
        tick();
        chk_after("basic", 16'd1);
    endtask

    task automatic test_negative();
        logic [15:0] v[6];
        v = '{16'h8000, -16'sd5, -16'sd300, -16'sd5, 16'h8000, -16'sd6};
        for (int i = 0; i < 6; i++) push(v[i]);
        chk_result("neg", 3'd1, 16'hFFFB);
        tick();
        chk_after("neg", 16'd2);
    endtask

    task automatic test_stall();
        logic [15:0] v[6];
        v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd32767};
        output_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(v[i]);
        for (int c = 0; c < 10; c++) begin
            chk_result("stall", 3'd5, 16'd32767);
            checks++;
            if (input_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ir cyc=%0d got %0b want 0",
                         c, input_ready);
            end
            input_valid = (c == 3);
            input_data  = 16'd100;
            tick();
        end
        input_valid = 1'b0;
        output_ready = 1'b1;
        chk_result("stall_end", 3'd5, 16'd32767);
        tick();
        chk_after("stall", 16'd3);
    endtask

    task automatic test_bubbles();
        logic [15:0] v[12];
        int gaps[12];
        v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6,
              16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        gaps = '{2, 0, 1, 3, 0, 1, 0, 2, 0, 1, 4, 1};
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < gaps[i]; g++) tick();
            push(v[i]);
            if (i == 5) begin
                chk_result("bub_a", 3'd5, 16'd6);
                tick();
                chk_after("bub_a", 16'd4);
            end
        end
        chk_result("bub_b", 3'd0, 16'd6);
        tick();
        chk_after("bub_b", 16'd5);
    endtask

    task automatic test_reset_mid();
        logic [15:0] v[6];
        v = '{16'd9, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        push(16'd50);
        push(16'd60);
        push(16'd70);
        checks++;
        if (output_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_partial got ov=%0b want 0", output_valid);
        end
        #2 reset = 1'b0;
        #1;
        chk_after("mid_rst", 16'd0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) push(v[i]);
        chk_result("mid", 3'd0, 16'd9);
        tick();
        chk_after("mid", 16'd1);
    endtask

    task automatic test_wrap();
        logic [15:0] v[6];
        v = '{16'd4, 16'd8, 16'd2, 16'd8, 16'd1, 16'd0};
        force dut.vc_q = 16'hFFFE;
        #1;
        release dut.vc_q;
        #1;
        checks++;
        if (vec_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_preload got %0d want 65534", vec_count);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) push(v[i]);
            chk_result("wrap", 3'd1, 16'd8);
            tick();
            chk_after("wrap", (k == 0) ? 16'hFFFF : 16'h0000);
        end
        for (int i = 0; i < 6; i++) push(v[5 - i]);
        chk_result("wrap_post", 3'd2, 16'd8);
        tick();
        chk_after("wrap_post", 16'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_stall();
        test_bubbles();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
